// File: rtl/spi_ovs_slave_if.sv
// rtl/spi_ovs_slave_if.sv - byte-side rx/tx handshake bundle between the SPI front-end and the command decoder
interface spi_ovs_slave_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_first;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       quad_en;
    logic       tx_dir;

    modport slave (
        output rx_data, rx_valid, rx_first, tx_req,
        input  tx_data, quad_en, tx_dir
    );

    modport master (
        input  rx_data, rx_valid, rx_first, tx_req,
        output tx_data, quad_en, tx_dir
    );
endinterface

// File: rtl/spi_ovs_slave.sv
// rtl/spi_ovs_slave.sv - oversampled SPI/QSPI slave front-end; optional CS glitch counter under SPI_OVS_GLITCH_CNT_EN
module spi_ovs_slave #(
    parameter int SYNC_STAGES = 2,
    parameter int CS_FILTER   = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_spi_sck_in,
    input  logic           i_spi_cs_in,
    input  logic [3:0]     i_spi_d_in,
    output logic [3:0]     o_spi_d_out,
    output logic [3:0]     o_spi_d_oe,
    spi_ovs_slave_if.slave bus,
    output logic           o_cs_active,
    output logic           o_xfer_end,
    output logic [7:0]     o_glitch_count
);
    localparam logic [3:0] FILT_LAST = 4'(CS_FILTER - 1);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA} state_t;

    logic [SYNC_STAGES-1:0]      r_sck_sync;
    logic [SYNC_STAGES-1:0]      r_cs_sync;
    logic [SYNC_STAGES-1:0][3:0] r_d_sync;
    logic                        r_sck_d;
    logic                        w_sck_s;
    logic                        w_cs_s;
    logic [3:0]                  w_d_s;
    logic                        w_sck_rise;
    logic                        w_sck_fall;

    logic                        r_cs_act;
    logic [3:0]                  r_filt_cnt;
    logic                        w_cs_mis;

    state_t                      r_state;
    logic [2:0]                  r_bit_cnt;
    logic [6:0]                  r_rx_sh;
    logic [7:0]                  r_tx_sh;
    logic [7:0]                  r_rx_data;
    logic                        r_rx_valid;
    logic                        r_rx_first;
    logic                        r_tx_req;
    logic                        r_xfer_end;
    logic                        r_quad;
    logic                        r_load_pend;
    logic                        w_quad_phase;
    logic [7:0]                  w_rx_next;
    logic                        w_byte_done;
    logic [3:0]                  w_d_out;
    logic [3:0]                  w_d_oe;

    // Synchronise the raw pads into clk and keep one extra SCK flop for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sck_sync <= '0;
            r_cs_sync  <= '1;
            r_d_sync   <= '0;
            r_sck_d    <= 1'b0;
        end else begin
            r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], i_spi_sck_in};
            r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], i_spi_cs_in};
            r_d_sync   <= {r_d_sync[SYNC_STAGES-2:0], i_spi_d_in};
            r_sck_d    <= w_sck_s;
        end
    end

    assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
    assign w_cs_s     = r_cs_sync[SYNC_STAGES-1];
    assign w_d_s      = r_d_sync[SYNC_STAGES-1];
    assign w_sck_rise = w_sck_s & ~r_sck_d;
    assign w_sck_fall = ~w_sck_s & r_sck_d;

    // Raw CS is active low, so a mismatch is a synced level equal to the active-high filtered flag
    assign w_cs_mis = (w_cs_s == r_cs_act);

    // CS filter: the filtered level follows only after CS_FILTER consecutive mismatched samples
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cs_act   <= 1'b0;
            r_filt_cnt <= 4'd0;
        end else if (w_cs_mis) begin
            if (r_filt_cnt == FILT_LAST) begin
                r_cs_act   <= ~r_cs_act;
                r_filt_cnt <= 4'd0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 4'd1;
            end
        end else begin
            r_filt_cnt <= 4'd0;
        end
    end

`ifdef SPI_OVS_GLITCH_CNT_EN
    logic [7:0] r_glitch_cnt;
    logic       w_glitch;

    // A pulse is rejected when the synced level returns before the filter counter completes
    assign w_glitch = !w_cs_mis && (r_filt_cnt != 4'd0);

    // Saturating count of rejected CS pulses, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_glitch_cnt <= 8'd0;
        end else if (w_glitch && (r_glitch_cnt != 8'hFF)) begin
            r_glitch_cnt <= r_glitch_cnt + 8'd1;
        end
    end

    assign o_glitch_count = r_glitch_cnt;
`else
    assign o_glitch_count = 8'd0;
`endif

    assign w_quad_phase = (r_state == S_DATA) && r_quad;
    assign w_rx_next    = w_quad_phase ? {r_rx_sh[3:0], w_d_s} : {r_rx_sh, w_d_s[0]};
    assign w_byte_done  = w_quad_phase ? (r_bit_cnt == 3'd1) : (r_bit_cnt == 3'd7);

    // Transfer sequencing: command byte, data bytes, tx reload on fall, CS deassert has priority
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= 3'd0;
            r_rx_sh     <= 7'd0;
            r_tx_sh     <= 8'd0;
            r_rx_data   <= 8'd0;
            r_rx_valid  <= 1'b0;
            r_rx_first  <= 1'b0;
            r_tx_req    <= 1'b0;
            r_xfer_end  <= 1'b0;
            r_quad      <= 1'b0;
            r_load_pend <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_rx_first <= 1'b0;
            r_tx_req   <= 1'b0;
            r_xfer_end <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_cs_act) begin
                        r_state     <= S_CMD;
                        r_bit_cnt   <= 3'd0;
                        r_rx_sh     <= 7'd0;
                        r_quad      <= 1'b0;
                        r_load_pend <= 1'b0;
                        r_tx_sh     <= bus.tx_data;
                        r_tx_req    <= 1'b1;
                    end
                end
                S_CMD, S_DATA: begin
                    if (!r_cs_act) begin
                        r_state     <= S_IDLE;
                        r_xfer_end  <= 1'b1;
                        r_bit_cnt   <= 3'd0;
                        r_load_pend <= 1'b0;
                    end else if (w_sck_rise) begin
                        r_rx_sh <= w_rx_next[6:0];
                        if (w_byte_done) begin
                            r_bit_cnt   <= 3'd0;
                            r_rx_data   <= w_rx_next;
                            r_rx_valid  <= 1'b1;
                            r_rx_first  <= (r_state == S_CMD);
                            r_load_pend <= 1'b1;
                            if (r_state == S_CMD) begin
                                r_quad  <= bus.quad_en;
                                r_state <= S_DATA;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end else if (w_sck_fall) begin
                        if (r_load_pend) begin
                            r_tx_sh     <= bus.tx_data;
                            r_tx_req    <= 1'b1;
                            r_load_pend <= 1'b0;
                        end else if (w_quad_phase) begin
                            r_tx_sh <= {r_tx_sh[3:0], 4'h0};
                        end else begin
                            r_tx_sh <= {r_tx_sh[6:0], 1'b0};
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Lane drive: single lane on D1 in CMD/DATA, all four lanes only for a quad read data phase
    always_comb begin
        w_d_out = 4'h0;
        w_d_oe  = 4'h0;
        if (w_quad_phase) begin
            if (bus.tx_dir) begin
                w_d_out = r_tx_sh[7:4];
                w_d_oe  = 4'hF;
            end
        end else if (r_state != S_IDLE) begin
            w_d_out = {2'b00, r_tx_sh[7], 1'b0};
            w_d_oe  = 4'b0010;
        end
    end

    assign o_spi_d_out  = w_d_out;
    assign o_spi_d_oe   = w_d_oe;
    assign o_cs_active  = r_cs_act;
    assign o_xfer_end   = r_xfer_end;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;
    assign bus.rx_first = r_rx_first;
    assign bus.tx_req   = r_tx_req;
endmodule

// File: tb/tb_spi_ovs_slave.sv
// tb/tb_spi_ovs_slave.sv - directed table-driven bench for spi_ovs_slave
module tb_spi_ovs_slave;
`ifdef SPI_OVS_GLITCH_CNT_EN
    localparam int GL_ONE = 1;
    localparam int GL_SAT = 255;
`else
    localparam int GL_ONE = 0;
    localparam int GL_SAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       sck;
    logic       cs;
    logic [3:0] d_in;
    logic [3:0] d_out;
    logic [3:0] d_oe;
    logic       cs_active;
    logic       xfer_end;
    logic [7:0] glitch;

    spi_ovs_slave_if bus_if ();

    spi_ovs_slave dut (
        .clk            (clk),
        .rst            (rst),
        .i_spi_sck_in   (sck),
        .i_spi_cs_in    (cs),
        .i_spi_d_in     (d_in),
        .o_spi_d_out    (d_out),
        .o_spi_d_oe     (d_oe),
        .bus            (bus_if),
        .o_cs_active    (cs_active),
        .o_xfer_end     (xfer_end),
        .o_glitch_count (glitch)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // event monitor, sampled on the falling clock edge
    logic [8:0] rx_log [0:511];
    int rx_n = 0, tx_cnt = 0, xe_cnt = 0, cs_cyc = 0, xe_oe_bad = 0;
    always @(negedge clk) begin
        if (bus_if.rx_valid) begin
            rx_log[rx_n] = {bus_if.rx_first, bus_if.rx_data};
            rx_n = rx_n + 1;
        end
        if (bus_if.tx_req) tx_cnt = tx_cnt + 1;
        if (xfer_end) begin
            xe_cnt = xe_cnt + 1;
            if (d_oe != 4'h0) xe_oe_bad = xe_oe_bad + 1;
        end
        if (cs_active) cs_cyc = cs_cyc + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // nb bits (single) or nibbles (quad), SCK = clk/8, lanes sampled just before each rise
    task automatic send_byte(input logic [7:0] b, input bit quad, input int nb,
                             input logic [3:0] exp_oe, output logic [7:0] out, output int oe_bad);
        out    = 8'h00;
        oe_bad = 0;
        for (int i = 0; i < nb; i++) begin
            if (quad) d_in = b[7-4*i -: 4];
            else      d_in = {3'b000, b[7-i]};
            clks(4);
            if (quad) out = {out[3:0], d_out};
            else      out = {out[6:0], d_out[1]};
            if (d_oe !== exp_oe) oe_bad++;
            sck = 1'b1;
            clks(4);
            sck = 1'b0;
        end
    endtask

    typedef struct {
        bit          quad;
        bit          dir;
        logic [7:0]  tx0;
        logic [7:0]  tx1;
        logic [23:0] mosi;
        logic [23:0] exp_rx;
        logic [23:0] exp_out;
        logic [3:0]  exp_oe;
    } vec_t;

    vec_t vecs [3];

    initial begin
        logic [7:0] out;
        int         oe_bad, oe_acc, b_rx, b_tx, b_xe, b_cs;

        vecs[0] = '{quad: 1'b0, dir: 1'b0, tx0: 8'h5A, tx1: 8'hC7, mosi: 24'h03A53C,
                    exp_rx: 24'h03A53C, exp_out: 24'h5AC7C7, exp_oe: 4'b0010};
        vecs[1] = '{quad: 1'b1, dir: 1'b0, tx0: 8'h11, tx1: 8'h22, mosi: 24'h38C31F,
                    exp_rx: 24'h38C31F, exp_out: 24'h110000, exp_oe: 4'h0};
        vecs[2] = '{quad: 1'b1, dir: 1'b1, tx0: 8'h9E, tx1: 8'h9E, mosi: 24'h6B00F0,
                    exp_rx: 24'h6B00F0, exp_out: 24'h9E9E9E, exp_oe: 4'hF};

        rst = 1'b1; sck = 1'b0; cs = 1'b1; d_in = 4'h0;
        bus_if.tx_data = 8'h00; bus_if.quad_en = 1'b0; bus_if.tx_dir = 1'b0;
        clks(5);
        check("rst_rx_data", bus_if.rx_data, 8'h00);
        check("rst_rx_valid", bus_if.rx_valid, 1'b0);
        check("rst_rx_first", bus_if.rx_first, 1'b0);
        check("rst_tx_req", bus_if.tx_req, 1'b0);
        check("rst_cs_active", cs_active, 1'b0);
        check("rst_xfer_end", xfer_end, 1'b0);
        check("rst_glitch", glitch, 8'h00);
        check("rst_d_out", d_out, 4'h0);
        check("rst_d_oe", d_oe, 4'h0);
        rst = 1'b0;
        clks(5);

        // full transfers: command byte plus two data bytes each
        for (int v = 0; v < 3; v++) begin
            b_rx = rx_n; b_tx = tx_cnt; b_xe = xe_cnt;
            bus_if.quad_en = vecs[v].quad;
            bus_if.tx_dir  = vecs[v].dir;
            bus_if.tx_data = vecs[v].tx0;
            cs = 1'b0;
            clks(10);
            check($sformatf("cs_active_v%0d", v), cs_active, 1'b1);
            bus_if.tx_data = vecs[v].tx1;
            send_byte(vecs[v].mosi[23:16], 1'b0, 8, 4'b0010, out, oe_bad);
            check($sformatf("cmd_oe_v%0d", v), oe_bad, 0);
            check($sformatf("cmd_out_v%0d", v), out, vecs[v].exp_out[23:16]);
            clks(4);
            check($sformatf("tx_req_cnt_v%0d", v), tx_cnt - b_tx, 2);
            oe_acc = 0;
            for (int k = 1; k < 3; k++) begin
                send_byte(vecs[v].mosi[23-8*k -: 8], vecs[v].quad, vecs[v].quad ? 2 : 8,
                          vecs[v].exp_oe, out, oe_bad);
                oe_acc += oe_bad;
                check($sformatf("data_out%0d_v%0d", k, v), out, vecs[v].exp_out[23-8*k -: 8]);
            end
            check($sformatf("data_oe_v%0d", v), oe_acc, 0);
            clks(4);
            cs = 1'b1;
            clks(12);
            check($sformatf("rx_count_v%0d", v), rx_n - b_rx, 3);
            for (int k = 0; k < 3; k++)
                check($sformatf("rx%0d_v%0d", k, v), rx_log[b_rx + k],
                      {k == 0, vecs[v].exp_rx[23-8*k -: 8]});
            check($sformatf("xfer_end_v%0d", v), xe_cnt - b_xe, 1);
            check($sformatf("end_oe_v%0d", v), d_oe, 4'h0);
            check($sformatf("end_cs_v%0d", v), cs_active, 1'b0);
        end

        // CS low for exactly CS_FILTER clocks is accepted
        b_cs = cs_cyc; b_xe = xe_cnt;
        cs = 1'b0; clks(3); cs = 1'b1; clks(12);
        check("filter_edge_cs_cycles", cs_cyc - b_cs, 3);
        check("filter_edge_xfer_end", xe_cnt - b_xe, 1);
        check("filter_edge_glitch", glitch, 8'h00);

        // CS low for CS_FILTER-1 clocks is rejected
        b_cs = cs_cyc;
        cs = 1'b0; clks(2); cs = 1'b1; clks(8);
        check("glitch_cs_active", cs_cyc - b_cs, 0);
        check("glitch_count_one", glitch, GL_ONE);
        for (int i = 0; i < 299; i++) begin
            cs = 1'b0; clks(2); cs = 1'b1; clks(6);
        end
        check("glitch_cs_active_300", cs_cyc - b_cs, 0);
        check("glitch_count_sat", glitch, GL_SAT);

        // abort after 5 rises of the second byte
        b_rx = rx_n; b_xe = xe_cnt;
        bus_if.quad_en = 1'b0; bus_if.tx_dir = 1'b0; bus_if.tx_data = 8'h00;
        cs = 1'b0; clks(10);
        send_byte(8'h0B, 1'b0, 8, 4'b0010, out, oe_bad);
        send_byte(8'hFF, 1'b0, 5, 4'b0010, out, oe_bad);
        cs = 1'b1; clks(12);
        check("abort_rx_count", rx_n - b_rx, 1);
        check("abort_rx_cmd", rx_log[b_rx], {1'b1, 8'h0B});
        check("abort_xfer_end", xe_cnt - b_xe, 1);
        check("abort_oe", d_oe, 4'h0);
        b_rx = rx_n;
        cs = 1'b0; clks(10);
        send_byte(8'h9F, 1'b0, 8, 4'b0010, out, oe_bad);
        clks(4); cs = 1'b1; clks(12);
        check("after_abort_rx_count", rx_n - b_rx, 1);
        check("after_abort_rx_first", rx_log[b_rx], {1'b1, 8'h9F});
        check("xfer_end_oe", xe_oe_bad, 0);

        // reset during command bit 4
        b_rx = rx_n; b_xe = xe_cnt;
        cs = 1'b0; clks(10);
        send_byte(8'h02, 1'b0, 4, 4'b0010, out, oe_bad);
        d_in = 4'h0; clks(2);
        rst = 1'b1; cs = 1'b1;
        clks(1);
        check("rst_mid_outputs",
              {bus_if.rx_data, bus_if.rx_valid, bus_if.rx_first, bus_if.tx_req,
               cs_active, xfer_end, d_out, d_oe}, 0);
        check("rst_mid_glitch", glitch, 8'h00);
        clks(2); rst = 1'b0; clks(10);
        check("rst_mid_no_xfer_end", xe_cnt - b_xe, 0);
        check("rst_mid_no_rx", rx_n - b_rx, 0);
        cs = 1'b0; clks(10);
        send_byte(8'h02, 1'b0, 8, 4'b0010, out, oe_bad);
        clks(4); cs = 1'b1; clks(12);
        check("post_rst_rx_count", rx_n - b_rx, 1);
        check("post_rst_rx", rx_log[b_rx], {1'b1, 8'h02});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
